multiword_add_ctrl: RTL and testbench
=====================================

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 SHALL have parameter Width, default 4: bit width of the single adder slice, the word size.
REQ-002 SHALL have parameter Words, default 4: number of words per operand, Words >= 1.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid_i, input, 1 bit: operand request valid.
REQ-006 SHALL have port in_ready_o, output, 1 bit: controller can accept a request.
REQ-007 SHALL have port a_i, input, Width*Words bits: operand A.
REQ-008 SHALL have port b_i, input, Width*Words bits: operand B.
REQ-009 SHALL have port carry_i, input, 1 bit: carry-in; used for add only.
REQ-010 SHALL have port sub_i, input, 1 bit: 1 selects A-B, 0 selects A+B+carry_i.
REQ-011 SHALL have port out_valid_o, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready_i, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port result_o, output, Width*Words bits: sum or difference.
REQ-014 SHALL have port carry_o, output, 1 bit: final carry-out; for sub, 1 means no borrow.
REQ-015 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL run an FSM with states IDLE, ADD and DONE.
REQ-017 SHALL assert in_ready_o only in IDLE.
REQ-018 SHALL, on in_valid_i && in_ready_o, latch a_i, b_i, carry_i and sub_i, clear the word counter and result register, and go to ADD.
REQ-019 SHALL, in ADD, process one word per cycle, least-significant first, through a single Width-bit adder slice.
REQ-020 SHALL feed the word-0 slice carry-in as carry_i for add and as 1 for sub.
REQ-021 SHALL feed each later word's slice carry-in from the previous slice carry-out, held in a carry register.
REQ-022 SHALL invert the B word before the slice when sub is latched.
REQ-023 SHALL write slice output word k into result_o[k*Width +: Width] in ADD cycle k.
REQ-024 SHALL, after word Words-1, register the slice carry-out into carry_o and go to DONE; latency is exactly Words cycles from accept to out_valid_o.
REQ-025 SHALL assert out_valid_o only in DONE, holding result_o and carry_o stable until out_ready_i.
REQ-026 SHALL, in DONE with out_ready_i=1, go to IDLE on the next edge; in_ready_o rises then, giving Words+2 cycles minimum request spacing.
REQ-027 SHALL ignore changes on a_i, b_i, carry_i, sub_i and in_valid_i outside the accept cycle.
REQ-028 SHALL take no action on out_ready_i outside DONE.
REQ-029 SHALL, with Words=1, spend exactly one cycle in ADD.
REQ-030 SHALL size the word counter at max(1,$clog2(Words)) bits, never wrapping past Words-1.

Reset
REQ-031 SHALL, on rst_ni low, go to IDLE immediately, including mid-ADD or in DONE, discarding any operation in progress.
REQ-032 SHALL, on reset, clear result_o, carry_o, out_valid_o, busy_o, the counter and the carry register.
REQ-033 SHALL drive in_ready_o high during reset.
REQ-034 SHALL accept its first request on the first edge after rst_ni is released.

Structure
REQ-035 SHALL place the FSM state encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2) in the shared package/header multiword_add_pkg, included by RTL and bench.
REQ-036 SHALL instantiate the existing carry-lookahead slice cl_adder_w_cin with Width as its only sub-module.
REQ-037 SHALL keep the operand, counter and FSM logic inside this block.

Verification (Width=4, Words=4 unless stated)
REQ-038 SHALL cover: A=0xFFFF, B=0x0001, carry_i=0, add -> out_valid_o exactly 4 cycles after accept, result 0x0000, carry_o=1.
REQ-039 SHALL cover: A=0x1234, B=0x4321, carry_i=1, add -> result 0x5556, carry_o=0.
REQ-040 SHALL cover: A=0x0005, B=0x0007, sub -> result 0xFFFE, carry_o=0 (borrow).
REQ-041 SHALL cover: out_ready_i held low 3 cycles in DONE, operands changed meanwhile -> result_o and carry_o stable, in_ready_o low; release -> IDLE next edge.
REQ-042 SHALL cover: rst_ni pulsed low during ADD cycle 2 -> all outputs 0, in_ready_o=1, and the next request completes correctly.
REQ-043 SHALL cover: Words=1, A=0x4, B=0xF, carry_i=1 -> out_valid_o 1 cycle after accept, result 0x4, carry_o=1.

Source files
------------

// File: rtl/multiword_add_pkg.sv
// Shared definitions for the multi-word add/subtract controller:
// FSM state encodings and word-counter sizing.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One counter bit is kept even for a single-word operand.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cl_adder_w_cin.sv
// Width-bit carry-lookahead adder slice with carry-in and carry-out.
// Every carry is expanded directly from generate/propagate terms.
module cl_adder_w_cin #(
  parameter int Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             carry_i,
  output logic [Width-1:0] sum_o,
  output logic             carry_o
);

  logic [Width-1:0] gen_s;
  logic [Width-1:0] prop_s;
  logic [Width:0]   carry_s;

  assign gen_s  = a_i & b_i;
  assign prop_s = a_i ^ b_i;

  // carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
  always_comb begin
    logic pp;
    logic cc;
    carry_s    = '0;
    carry_s[0] = carry_i;
    for (int i = 0; i < Width; i++) begin
      cc = gen_s[i];
      pp = prop_s[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc = cc | (pp & gen_s[j]);
        pp = pp & prop_s[j];
      end
      carry_s[i+1] = cc | (pp & carry_i);
    end
  end

  assign sum_o   = prop_s ^ carry_s[Width-1:0];
  assign carry_o = carry_s[Width];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Serial multi-word adder/subtractor: one Width-bit slice processes one word
// per cycle, least-significant first, behind a valid/ready handshake.
module multiword_add_ctrl
  import multiword_add_pkg::*;
#(
  parameter int Width = 4,
  parameter int Words = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [Width*Words-1:0] a_i,
  input  logic [Width*Words-1:0] b_i,
  input  logic                   carry_i,
  input  logic                   sub_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [Width*Words-1:0] result_o,
  output logic                   carry_o,
  output logic                   busy_o
);

  localparam int TotW = Width * Words;
  localparam int CntW = cnt_width(Words);
  localparam logic [CntW-1:0] LastCnt = CntW'(Words - 1);

  state_e           state_r;
  state_e           state_s;
  logic [TotW-1:0]  a_r;
  logic [TotW-1:0]  b_r;
  logic [TotW-1:0]  result_r;
  logic             sub_r;
  logic             carry_r;
  logic             carry_out_r;
  logic [CntW-1:0]  cnt_r;

  logic             accept_s;
  logic             last_word_s;
  logic [Width-1:0] a_word_s;
  logic [Width-1:0] b_word_s;
  logic [Width-1:0] b_oper_s;
  logic [Width-1:0] sum_s;
  logic             slice_cout_s;

  assign accept_s    = in_valid_i && (state_r == IDLE);
  assign last_word_s = (cnt_r == LastCnt);

  // Select the operand words addressed by the word counter.
  always_comb begin
    a_word_s = '0;
    b_word_s = '0;
    for (int w = 0; w < Words; w++) begin
      if (cnt_r == CntW'(w)) begin
        a_word_s = a_r[w*Width +: Width];
        b_word_s = b_r[w*Width +: Width];
      end else begin
        a_word_s = a_word_s;
        b_word_s = b_word_s;
      end
    end
  end

  assign b_oper_s = sub_r ? ~b_word_s : b_word_s;

  cl_adder_w_cin #(
    .Width (Width)
  ) u_slice (
    .a_i     (a_word_s),
    .b_i     (b_oper_s),
    .carry_i (carry_r),
    .sum_o   (sum_s),
    .carry_o (slice_cout_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = ADD;
        else          state_s = IDLE;
      end
      ADD: begin
        if (last_word_s) state_s = DONE;
        else             state_s = ADD;
      end
      DONE: begin
        if (out_ready_i) state_s = IDLE;
        else             state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, word sequencing and result accumulation.
  // The carry register is seeded at accept so word 0 sees carry_i (add) or 1 (sub).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_r         <= '0;
      b_r         <= '0;
      sub_r       <= 1'b0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r         <= a_i;
            b_r         <= b_i;
            sub_r       <= sub_i;
            carry_r     <= sub_i ? 1'b1 : carry_i;
            cnt_r       <= '0;
            result_r    <= '0;
            carry_out_r <= 1'b0;
          end
        end
        ADD: begin
          for (int w = 0; w < Words; w++) begin
            if (cnt_r == CntW'(w)) result_r[w*Width +: Width] <= sum_s;
          end
          carry_r <= slice_cout_s;
          if (last_word_s) carry_out_r <= slice_cout_s;
          else             cnt_r       <= cnt_r + CntW'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_r == IDLE);
  assign out_valid_o = (state_r == DONE);
  assign busy_o      = (state_r != IDLE);
  assign result_o    = result_r;
  assign carry_o     = carry_out_r;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed bench for multiword_add_ctrl: a Words=4 instance for the main
// scenarios and a Words=1 instance for the single-word case.
module tb_multiword_add_ctrl;
  import multiword_add_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, out_ready = 1'b0, carry_in = 1'b0, sub_in = 1'b0;
  logic [15:0] a_in = 16'h0, b_in = 16'h0;
  logic        in_ready, out_valid, carry_out, busy;
  logic [15:0] result;

  logic       v1 = 1'b0, or1 = 1'b0, c1 = 1'b0, s1 = 1'b0;
  logic [3:0] a1 = 4'h0, b1 = 4'h0;
  logic       ir1, ov1, co1, busy1;
  logic [3:0] res1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  multiword_add_ctrl #(.Width(4), .Words(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a_in), .b_i(b_in), .carry_i(carry_in), .sub_i(sub_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .carry_o(carry_out), .busy_o(busy)
  );

  multiword_add_ctrl #(.Width(4), .Words(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v1), .in_ready_o(ir1),
    .a_i(a1), .b_i(b1), .carry_i(c1), .sub_i(s1),
    .out_valid_o(ov1), .out_ready_i(or1), .result_o(res1),
    .carry_o(co1), .busy_o(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic [15:0] er,
                        input logic ec, input bit hold);
    int lat;
    @(negedge clk);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    a_in = a; b_in = b; carry_in = c; sub_in = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = ~a; b_in = 16'h5a5a; carry_in = ~c; sub_in = ~s;
    check({tag, "_ready_low"}, in_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_result"}, result, er);
    check({tag, "_carry"}, carry_out, ec);
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        a_in = 16'h1111 * (i + 1); b_in = ~a_in; in_valid = 1'b1; sub_in = ~sub_in;
        @(posedge clk); #1;
        check({tag, "_hold_result"}, result, er);
        check({tag, "_hold_carry"}, carry_out, ec);
        check({tag, "_hold_ready"}, in_ready, 1'b0);
        check({tag, "_hold_valid"}, out_valid, 1'b1);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, in_ready, 1'b1);
    check({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    #12;
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_carry", carry_out, 1'b0);
    check("rst_state", dut.state_r, IDLE);
    #5 rst_n = 1'b1;

    run_op("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b0 | 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_noborrow", 16'h9000, 16'h1234, 1'b1, 1'b1, 16'h7DCC, 1'b1, 1'b0);
    run_op("hold", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b1);

    // Reset pulse in ADD cycle 2, after words 0 and 1 have been written.
    @(negedge clk);
    a_in = 16'h1111; b_in = 16'h2222; carry_in = 1'b0; sub_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_state", dut.state_r, IDLE);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_result", result, 16'h0000);
    check("midrst_carry", carry_out, 1'b0);
    #3 rst_n = 1'b1;
    run_op("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    // Single-word instance.
    @(negedge clk);
    a1 = 4'h4; b1 = 4'hF; c1 = 1'b1; s1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
    check("w1_busy", busy1, 1'b1);
    check("w1_valid_early", ov1, 1'b0);
    @(posedge clk); #1;
    check("w1_valid", ov1, 1'b1);
    check("w1_result", res1, 4'h4);
    check("w1_carry", co1, 1'b1);
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    check("w1_idle_ready", ir1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
